// File: rtl/div_seq_n.sv
// rtl/div_seq_n.sv - radix-2 restoring shift/subtract divider, fixed BITS+1 clock latency
//
// Purpose:
//   Sequential divider between the calculator operand registers and the
//   result/display path. Operands are latched on the accepting edge, BITS
//   restoring iterations run, and one DONE cycle loads the registered result
//   and pulses rdy. A zero divisor skips RUN and goes straight to DONE.
//
// Configuration macro:
//   DIV_SIGNED_EN - when defined, sgn=1 selects two's-complement operation
//                   (magnitudes divided, sign fix-up in DONE, truncation
//                   toward zero). When undefined, sgn is ignored and every
//                   operation is unsigned.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   start    in   request, sampled only in IDLE
//   a        in   [BITS-1:0] dividend, captured on the accepting edge
//   b        in   [BITS-1:0] divisor, captured on the accepting edge
//   sgn      in   1 = signed operation (DIV_SIGNED_EN builds only)
//   div      out  [BITS-1:0] quotient, registered
//   mod      out  [BITS-1:0] remainder, registered
//   div_err  out  divide-by-zero flag for the last result
//   rdy      out  one-clock completion pulse
//   busy     out  high from the accepting edge until the edge asserting rdy

module div_seq_n #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            sgn,
    output logic [BITS-1:0] div,
    output logic [BITS-1:0] mod,
    output logic            div_err,
    output logic            rdy,
    output logic            busy
);

    localparam int CNT_W = (BITS > 2) ? $clog2(BITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    // Partial remainder. After every restore it is strictly less than the
    // divisor, so only BITS bits need to be kept; the shifted value used
    // for the trial subtraction is BITS+1 bits.
    logic [BITS-1:0] r_rem;
    logic [BITS-1:0] r_quo;
    logic [BITS-1:0] r_dsr;
    logic [BITS-1:0] r_a;
    logic            r_err;

    logic [BITS-1:0] r_div;
    logic [BITS-1:0] r_mod;
    logic            r_derr;
    logic            r_rdy;
    logic            r_busy;

    logic [BITS:0]   w_rem_sh;
    logic [BITS:0]   w_trial;
    logic [BITS-1:0] w_a_mag;
    logic [BITS-1:0] w_b_mag;
    logic [BITS-1:0] w_q_fix;
    logic [BITS-1:0] w_r_fix;

    logic            w_busy_nxt;
    logic            w_rdy_nxt;
    logic [BITS-1:0] w_div_nxt;
    logic [BITS-1:0] w_mod_nxt;
    logic            w_err_nxt;

    assign w_rem_sh = {r_rem, r_quo[BITS-1]};
    // MSB of the BITS+1 bit difference is the borrow: set means restore.
    assign w_trial  = w_rem_sh - {1'b0, r_dsr};

`ifdef DIV_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_neg = sgn & a[BITS-1];
    assign w_b_neg = sgn & b[BITS-1];
    assign w_a_mag = w_a_neg ? (~a + BITS'(1)) : a;
    assign w_b_mag = w_b_neg ? (~b + BITS'(1)) : b;
    // -2^(BITS-1) / -1 needs no special case: the magnitude quotient is
    // 2^(BITS-1) and, with no negation, reads back as -2^(BITS-1).
    assign w_q_fix = r_neg_q ? (~r_quo + BITS'(1)) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem + BITS'(1)) : r_rem;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    logic w_sgn_unused;

    assign w_sgn_unused = sgn;
    assign w_a_mag      = a;
    assign w_b_mag      = b;
    assign w_q_fix      = r_quo;
    assign w_r_fix      = r_rem;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (b == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_busy_nxt = 1'b0;
        w_rdy_nxt  = 1'b0;
        w_div_nxt  = r_div;
        w_mod_nxt  = r_mod;
        w_err_nxt  = r_derr;
        case (r_state)
            S_IDLE: w_busy_nxt = start;
            S_RUN:  w_busy_nxt = 1'b1;
            S_DONE: begin
                w_rdy_nxt = 1'b1;
                if (r_err) begin
                    w_div_nxt = '1;
                    w_mod_nxt = r_a;
                    w_err_nxt = 1'b1;
                end else begin
                    w_div_nxt = w_q_fix;
                    w_mod_nxt = w_r_fix;
                    w_err_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dsr  <= '0;
            r_a    <= '0;
            r_err  <= 1'b0;
            r_div  <= '0;
            r_mod  <= '0;
            r_derr <= 1'b0;
            r_rdy  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_rdy  <= w_rdy_nxt;
            r_busy <= w_busy_nxt;
            r_div  <= w_div_nxt;
            r_mod  <= w_mod_nxt;
            r_derr <= w_err_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_err <= (b == '0);
                        r_cnt <= CNT_W'(BITS - 1);
                        r_rem <= '0;
                        r_quo <= w_a_mag;
                        r_dsr <= w_b_mag;
                    end
                end
                S_RUN: begin
                    r_rem <= w_trial[BITS] ? w_rem_sh[BITS-1:0] : w_trial[BITS-1:0];
                    r_quo <= {r_quo[BITS-2:0], ~w_trial[BITS]};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign div     = r_div;
    assign mod     = r_mod;
    assign div_err = r_derr;
    assign rdy     = r_rdy;
    assign busy    = r_busy;

endmodule

// File: tb/tb_div_seq_n.sv
// tb/tb_div_seq_n.sv - directed self-checking bench for div_seq_n (BITS=8)

module tb_div_seq_n;

    localparam int BITS = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [BITS-1:0] a = '0;
    logic [BITS-1:0] b = '0;
    logic            sgn = 1'b0;
    logic [BITS-1:0] div;
    logic [BITS-1:0] mod;
    logic            div_err;
    logic            rdy;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;

    div_seq_n #(.BITS(BITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .sgn     (sgn),
        .div     (div),
        .mod     (mod),
        .div_err (div_err),
        .rdy     (rdy),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus only: issues one start pulse and returns at the negedge where
    // rdy is first seen high; lat is edges after the accepting edge, -1 on timeout.
    task automatic do_op(input logic [BITS-1:0] ia, input logic [BITS-1:0] ib,
                         input logic isg, output int lat);
        @(negedge clk);
        a = ia; b = ib; sgn = isg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rdy) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({div, mod, div_err, rdy, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got div=%0d mod=%0d err=%b rdy=%b busy=%b, want all 0",
                     div, mod, div_err, rdy, busy);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        int busy_cnt;
        @(negedge clk);
        a = 8'd100; b = 8'd7; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'd3; b = 8'd3;
        busy_cnt = 0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            if (rdy) begin
                lat = k;
                break;
            end
        end
        n_vec++;
        if (lat !== 9) begin n_err++; $display("FAIL basic_latency: got %0d want 9", lat); end
        n_vec++;
        if (busy_cnt !== 9) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 9", busy_cnt); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_rdy: got %b want 0", busy); end
        n_vec++;
        if ({div, mod, div_err} !== {8'd14, 8'd2, 1'b0}) begin
            n_err++;
            $display("FAIL basic_result: got div=%0d mod=%0d err=%b want 14 2 0", div, mod, div_err);
        end
        @(negedge clk);
        n_vec++;
        if (rdy !== 1'b0) begin n_err++; $display("FAIL basic_rdy_pulse_width: rdy=%b want 0", rdy); end
        n_vec++;
        if ({div, mod} !== {8'd14, 8'd2}) begin
            n_err++;
            $display("FAIL basic_result_hold: got div=%0d mod=%0d want 14 2", div, mod);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(8'd55, 8'd0, 1'b0, lat);
        n_vec++;
        if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_vec++;
        if ({div, mod, div_err} !== {8'd255, 8'd55, 1'b1}) begin
            n_err++;
            $display("FAIL dz_result: got div=%0d mod=%0d err=%b want 255 55 1", div, mod, div_err);
        end
        do_op(8'd9, 8'd3, 1'b0, lat);
        n_vec++;
        if (lat !== 9) begin n_err++; $display("FAIL dz_next_latency: got %0d want 9", lat); end
        n_vec++;
        if ({div, mod, div_err} !== {8'd3, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL dz_next_result: got div=%0d mod=%0d err=%b want 3 0 0", div, mod, div_err);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] va [4] = '{8'd5, 8'd255, 8'd255, 8'd128};
        logic [7:0] vb [4] = '{8'd9, 8'd1,   8'd255, 8'd3};
        logic [7:0] vq [4] = '{8'd0, 8'd255, 8'd1,   8'd42};
        logic [7:0] vr [4] = '{8'd5, 8'd0,   8'd0,   8'd2};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 1'b0, lat);
            n_vec++;
            if (lat !== 9 || {div, mod, div_err} !== {vq[i], vr[i], 1'b0}) begin
                n_err++;
                $display("FAIL bound_%0d: %0d/%0d got div=%0d mod=%0d err=%b lat=%0d want %0d %0d 0 lat 9",
                         i, va[i], vb[i], div, mod, div_err, lat, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        int rdy_cnt;
        logic late_busy;
        logic [7:0] d;
        logic [7:0] m;
        @(negedge clk);
        a = 8'd200; b = 8'd10; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; rdy_cnt = 0; late_busy = 1'b0; d = '0; m = '0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin a = 8'd1; b = 8'd1; start = 1'b1; end
            if (k == 4) start = 1'b0;
            @(negedge clk);
            if (rdy) begin
                rdy_cnt++;
                if (lat < 0) begin lat = k; d = div; m = mod; end
            end
            if (lat > 0 && k > lat && busy) late_busy = 1'b1;
        end
        n_vec++;
        if (lat !== 9 || {d, m} !== {8'd20, 8'd0}) begin
            n_err++;
            $display("FAIL ignore_result: got div=%0d mod=%0d lat=%0d want 20 0 lat 9", d, m, lat);
        end
        n_vec++;
        if (rdy_cnt !== 1) begin n_err++; $display("FAIL ignore_rdy_count: got %0d want 1", rdy_cnt); end
        n_vec++;
        if (late_busy !== 1'b0) begin n_err++; $display("FAIL ignore_not_queued: busy after rdy=%b want 0", late_busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int rdy_cnt;
        @(negedge clk);
        a = 8'd100; b = 8'd7; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({div, mod, div_err, rdy, busy} !== '0) begin
            n_err++;
            $display("FAIL rmid_outputs: got div=%0d mod=%0d err=%b rdy=%b busy=%b want all 0",
                     div, mod, div_err, rdy, busy);
        end
        reset = 1'b1;
        rdy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rdy || busy) rdy_cnt++;
        end
        n_vec++;
        if (rdy_cnt !== 0) begin n_err++; $display("FAIL rmid_no_rdy: got %0d active cycles want 0", rdy_cnt); end
        do_op(8'd50, 8'd5, 1'b0, lat);
        n_vec++;
        if (lat !== 9 || {div, mod, div_err} !== {8'd10, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rmid_after: got div=%0d mod=%0d err=%b lat=%0d want 10 0 0 lat 9",
                     div, mod, div_err, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        logic [7:0] d1;
        logic [7:0] m1;
        logic [7:0] d2;
        logic [7:0] m2;
        lat1 = -1; lat2 = -1; d1 = '0; m1 = '0; d2 = '0; m2 = '0;
        @(negedge clk);
        a = 8'd100; b = 8'd7; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'd9; b = 8'd3;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rdy) begin
                if (lat1 < 0) begin
                    lat1 = k; d1 = div; m1 = mod;
                end else begin
                    lat2 = k; d2 = div; m2 = mod;
                    break;
                end
            end
        end
        start = 1'b0;
        n_vec++;
        if (lat1 !== 9 || {d1, m1} !== {8'd14, 8'd2}) begin
            n_err++;
            $display("FAIL b2b_first: got div=%0d mod=%0d lat=%0d want 14 2 lat 9", d1, m1, lat1);
        end
        n_vec++;
        if (lat2 !== 19 || {d2, m2} !== {8'd3, 8'd0}) begin
            n_err++;
            $display("FAIL b2b_second: got div=%0d mod=%0d lat=%0d want 3 0 lat 19", d2, m2, lat2);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        logic [7:0] va [4] = '{8'hF9, 8'h07, 8'h80, 8'hF9};
        logic [7:0] vb [4] = '{8'h02, 8'hFE, 8'hFF, 8'h02};
        logic       vs [4] = '{1'b1,  1'b1,  1'b1,  1'b0};
        logic [7:0] vq [4] = '{8'hFD, 8'hFD, 8'h80, 8'd124};
        logic [7:0] vr [4] = '{8'hFF, 8'h01, 8'h00, 8'd1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vs[i], lat);
            n_vec++;
            if (lat !== 9 || {div, mod, div_err} !== {vq[i], vr[i], 1'b0}) begin
                n_err++;
                $display("FAIL signed_%0d: a=%h b=%h sgn=%b got div=%h mod=%h err=%b lat=%0d want %h %h 0 lat 9",
                         i, va[i], vb[i], vs[i], div, mod, div_err, lat, vq[i], vr[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_boundaries();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
